patp_control_unit: RTL and testbench

Control sequencer for the PATP core: it drives the instruction register's load strobe and consumes the decoded opcode, the other end of the instruction register interface. It runs a fixed fetch/decode/execute state machine and emits per-cycle control strobes for the PC, MAR, memory, ALU and accumulator. It sits between the instruction register and the datapath and is the only source of `clk_ir`.

---
 rtl/patp_pkg.sv | 52 +++++
 rtl/patp_control_unit.sv | 157 +++++++++++++++
 tb/tb_patp_control_unit.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/patp_pkg.sv
// Shared encodings for the PATP core: opcodes, ALU operations, control-unit
// states, the control-strobe bundle and field widths.
package patp_pkg;

  localparam int unsigned OPCODE_W  = 3;
  localparam int unsigned OPERAND_W = 5;
  localparam int unsigned ALU_OP_W  = 2;

  localparam logic [OPCODE_W-1:0] OP_LDA = 3'b000;
  localparam logic [OPCODE_W-1:0] OP_STA = 3'b001;
  localparam logic [OPCODE_W-1:0] OP_ADD = 3'b010;
  localparam logic [OPCODE_W-1:0] OP_SUB = 3'b011;
  localparam logic [OPCODE_W-1:0] OP_JMP = 3'b100;
  localparam logic [OPCODE_W-1:0] OP_JZ  = 3'b101;
  localparam logic [OPCODE_W-1:0] OP_CLR = 3'b110;
  localparam logic [OPCODE_W-1:0] OP_HLT = 3'b111;

  localparam logic [ALU_OP_W-1:0] ALU_PASS = 2'b00;
  localparam logic [ALU_OP_W-1:0] ALU_ADD  = 2'b01;
  localparam logic [ALU_OP_W-1:0] ALU_SUB  = 2'b10;
  localparam logic [ALU_OP_W-1:0] ALU_CLR  = 2'b11;

  typedef enum logic [2:0] {
    ST_F0   = 3'd0,
    ST_F1   = 3'd1,
    ST_DEC  = 3'd2,
    ST_EX0  = 3'd3,
    ST_EX1  = 3'd4,
    ST_HALT = 3'd5
  } cu_state_e;

  // Per-cycle control strobes driven towards the IR and datapath.
  typedef struct packed {
    logic                clk_ir;
    logic                pc_inc;
    logic                pc_load;
    logic                mar_load;
    logic                mar_sel;
    logic                mem_rd;
    logic                mem_wr;
    logic                acc_load;
    logic [ALU_OP_W-1:0] alu_op;
    logic                fetch;
    logic                halted;
  } cu_ctrl_t;

  // Instructions that address memory through the IR operand.
  function automatic logic is_mem_op(input logic [OPCODE_W-1:0] op);
    return (op == OP_LDA) || (op == OP_STA) || (op == OP_ADD) || (op == OP_SUB);
  endfunction

endpackage

// File: rtl/patp_control_unit.sv
// PATP control sequencer: fixed fetch/decode/execute FSM producing the
// instruction-register load strobe and datapath control strobes.
//
// Ports:
//   clk       core clock, rising edge
//   rst       synchronous active-high reset
//   opcode    opcode field from the instruction register (used in DEC)
//   acc_zero  accumulator-is-zero flag (sampled in DEC only)
//   clk_ir    IR load enable
//   pc_inc / pc_load           PC increment / load from operand
//   mar_load / mar_sel         MAR load, source (0 PC, 1 operand)
//   mem_rd / mem_wr            memory read / write strobes
//   acc_load / alu_op          ACC load, ALU operation
//   fetch     first fetch cycle marker
//   halted    core stopped
//
// Build option: define PATP_CU_HALT_EN to make opcode 111 enter a HALT state
// that only reset leaves; otherwise 111 decodes as a 3-cycle NOP.
module patp_control_unit
  import patp_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic                acc_zero,
  output logic                clk_ir,
  output logic                pc_inc,
  output logic                pc_load,
  output logic                mar_load,
  output logic                mar_sel,
  output logic                mem_rd,
  output logic                mem_wr,
  output logic                acc_load,
  output logic [ALU_OP_W-1:0] alu_op,
  output logic                fetch,
  output logic                halted
);

  cu_state_e           state_q, state_d;
  logic [OPCODE_W-1:0] op_q, op_d;
  cu_ctrl_t            ctrl_c;
  cu_ctrl_t            out_c;

  // State and latched-opcode registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_F0;
      op_q    <= OP_LDA;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
    end
  end

  // Next-state and Moore output decode.
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    ctrl_c  = '0;
    case (state_q)
      ST_F0: begin
        ctrl_c.mar_load = 1'b1;
        ctrl_c.fetch    = 1'b1;
        state_d         = ST_F1;
      end
      ST_F1: begin
        ctrl_c.mem_rd = 1'b1;
        ctrl_c.clk_ir = 1'b1;
        ctrl_c.pc_inc = 1'b1;
        state_d       = ST_DEC;
      end
      ST_DEC: begin
        // The IR has just been loaded; opcode is valid this cycle only.
        op_d    = opcode;
        state_d = ST_F0;
        if (is_mem_op(opcode)) begin
          ctrl_c.mar_sel  = 1'b1;
          ctrl_c.mar_load = 1'b1;
          state_d         = ST_EX0;
        end else begin
          case (opcode)
            OP_JMP: ctrl_c.pc_load = 1'b1;
            OP_JZ:  ctrl_c.pc_load = acc_zero;
            OP_CLR: begin
              ctrl_c.alu_op   = ALU_CLR;
              ctrl_c.acc_load = 1'b1;
            end
            OP_HLT: begin
`ifdef PATP_CU_HALT_EN
              state_d = ST_HALT;
`else
              state_d = ST_F0;
`endif
            end
            default: state_d = ST_F0;
          endcase
        end
      end
      ST_EX0: begin
        state_d = ST_F0;
        if (op_q == OP_STA) begin
          ctrl_c.mem_wr = 1'b1;
        end else if (is_mem_op(op_q)) begin
          ctrl_c.mem_rd = 1'b1;
          state_d       = ST_EX1;
        end
      end
      ST_EX1: begin
        state_d = ST_F0;
        case (op_q)
          OP_LDA: begin
            ctrl_c.acc_load = 1'b1;
            ctrl_c.alu_op   = ALU_PASS;
          end
          OP_ADD: begin
            ctrl_c.acc_load = 1'b1;
            ctrl_c.alu_op   = ALU_ADD;
          end
          OP_SUB: begin
            ctrl_c.acc_load = 1'b1;
            ctrl_c.alu_op   = ALU_SUB;
          end
          default: ctrl_c = '0;
        endcase
      end
`ifdef PATP_CU_HALT_EN
      ST_HALT: begin
        ctrl_c.halted = 1'b1;
        state_d       = ST_HALT;
      end
`endif
      default: state_d = ST_F0;
    endcase
  end

  // While reset is held no strobe may fire; only the F0 fetch marker remains.
  always_comb begin
    out_c = ctrl_c;
    if (rst) begin
      out_c       = '0;
      out_c.fetch = ctrl_c.fetch;
    end
  end

  assign clk_ir   = out_c.clk_ir;
  assign pc_inc   = out_c.pc_inc;
  assign pc_load  = out_c.pc_load;
  assign mar_load = out_c.mar_load;
  assign mar_sel  = out_c.mar_sel;
  assign mem_rd   = out_c.mem_rd;
  assign mem_wr   = out_c.mem_wr;
  assign acc_load = out_c.acc_load;
  assign alu_op   = out_c.alu_op;
  assign fetch    = out_c.fetch;
  assign halted   = out_c.halted;

endmodule

// File: tb/tb_patp_control_unit.sv
// Scoreboard bench for patp_control_unit: a per-instruction reference model
// pushes the expected strobes of every cycle; a negedge monitor compares.
module tb_patp_control_unit;

`ifdef PATP_CU_HALT_EN
  localparam bit HALT_EN = 1'b1;
`else
  localparam bit HALT_EN = 1'b0;
`endif

  typedef struct packed {
    logic       clk_ir;
    logic       pc_inc;
    logic       pc_load;
    logic       mar_load;
    logic       mar_sel;
    logic       mem_rd;
    logic       mem_wr;
    logic       acc_load;
    logic [1:0] alu_op;
    logic       fetch;
    logic       halted;
  } sig_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] opcode = 3'b000;
  logic       acc_zero = 1'b0;
  logic       clk_ir, pc_inc, pc_load, mar_load, mar_sel;
  logic       mem_rd, mem_wr, acc_load, fetch, halted;
  logic [1:0] alu_op;

  patp_control_unit dut (
    .clk      (clk),
    .rst      (rst),
    .opcode   (opcode),
    .acc_zero (acc_zero),
    .clk_ir   (clk_ir),
    .pc_inc   (pc_inc),
    .pc_load  (pc_load),
    .mar_load (mar_load),
    .mar_sel  (mar_sel),
    .mem_rd   (mem_rd),
    .mem_wr   (mem_wr),
    .acc_load (acc_load),
    .alu_op   (alu_op),
    .fetch    (fetch),
    .halted   (halted)
  );

  always #5 clk = ~clk;

  sig_t act;
  assign act = {clk_ir, pc_inc, pc_load, mar_load, mar_sel, mem_rd, mem_wr,
                acc_load, alu_op, fetch, halted};

  sig_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  // Reference model: position inside the current instruction.
  int         m_phase = 0;
  logic [2:0] m_op = 3'b000;
  bit         m_halt = 1'b0;

  function automatic int instr_len(input logic [2:0] op);
    case (op)
      3'b000, 3'b010, 3'b011: return 5;
      3'b001:                 return 4;
      default:                return 3;
    endcase
  endfunction

  // Strobes expected in cycle 'ph' (0 = first fetch cycle) of instruction 'op'.
  function automatic sig_t expect_word(input int ph, input logic [2:0] op, input logic az);
    sig_t s;
    s = '0;
    case (ph)
      0: begin s.mar_load = 1'b1; s.fetch = 1'b1; end
      1: begin s.mem_rd = 1'b1; s.clk_ir = 1'b1; s.pc_inc = 1'b1; end
      2: begin
        if (op <= 3'd3) begin
          s.mar_sel = 1'b1; s.mar_load = 1'b1;
        end else if (op == 3'd4) begin
          s.pc_load = 1'b1;
        end else if (op == 3'd5) begin
          s.pc_load = az;
        end else if (op == 3'd6) begin
          s.acc_load = 1'b1; s.alu_op = 2'b11;
        end
      end
      3: begin
        if (op == 3'd1) s.mem_wr = 1'b1;
        else            s.mem_rd = 1'b1;
      end
      4: begin
        s.acc_load = 1'b1;
        s.alu_op   = (op == 3'd2) ? 2'b01 : (op == 3'd3) ? 2'b10 : 2'b00;
      end
      default: s = '0;
    endcase
    return s;
  endfunction

  // One clock cycle: drive inputs just after the edge, queue expected outputs,
  // then advance the model as the edge at the end of this cycle will.
  task automatic run_cycle(input logic r, input logic [2:0] op_in, input logic az);
    sig_t e;
    if (r) begin
      e = '0;
      e.fetch = !m_halt && (m_phase == 0);
    end else if (m_halt) begin
      e = '0;
      e.halted = 1'b1;
    end else begin
      e = expect_word(m_phase, (m_phase == 2) ? op_in : m_op, az);
    end
    @(posedge clk);
    #1;
    rst      = r;
    opcode   = op_in;
    acc_zero = az;
    exp_q.push_back(e);
    if (r) begin
      m_phase = 0;
      m_halt  = 1'b0;
    end else if (!m_halt) begin
      if (m_phase == 2) m_op = op_in;
      if (m_phase == 2 && op_in == 3'b111 && HALT_EN) begin
        m_halt  = 1'b1;
        m_phase = 0;
      end else if (m_phase + 1 >= instr_len(m_op)) begin
        m_phase = 0;
      end else begin
        m_phase = m_phase + 1;
      end
    end
  endtask

  // One instruction from F0; opcode/acc_zero are random outside DEC. rst_at
  // asserts reset in that phase (-1: none). A halt is held for halt_cycles.
  task automatic run_instr(input logic [2:0] op, input logic az, input int rst_at,
                           input int halt_cycles);
    int n;
    n = instr_len(op);
    for (int p = 0; p < n; p++) begin
      if (p == rst_at) begin
        run_cycle(1'b1, 3'($urandom), 1'($urandom));
        return;
      end
      if (p == 2) run_cycle(1'b0, op, az);
      else        run_cycle(1'b0, 3'($urandom), 1'($urandom));
    end
    if (m_halt) begin
      for (int h = 0; h < halt_cycles; h++) run_cycle(1'b0, 3'($urandom), 1'($urandom));
      run_cycle(1'b1, 3'($urandom), 1'($urandom));
    end
  endtask

  // Monitor: compare every presented cycle against the scoreboard.
  always @(negedge clk) begin
    sig_t e;
    cyc = cyc + 1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks = checks + 1;
      if (act !== e) begin
        errors = errors + 1;
        $display("FAIL strobes cyc=%0d got=%b want=%b", cyc, act, e);
      end
      checks = checks + 1;
      if ((pc_inc && pc_load) || (mem_rd && mem_wr)) begin
        errors = errors + 1;
        $display("FAIL exclusive cyc=%0d pc_inc/pc_load=%b%b mem_rd/mem_wr=%b%b want no overlap",
                 cyc, pc_inc, pc_load, mem_rd, mem_wr);
      end
      checks = checks + 1;
      if (!acc_load && alu_op != 2'b00) begin
        errors = errors + 1;
        $display("FAIL alu_idle cyc=%0d alu_op=%b acc_load=0 want alu_op=00", cyc, alu_op);
      end
    end
  end

  initial begin
    int op, rat;
    // Reset held two cycles, then directed instructions.
    run_cycle(1'b1, 3'b000, 1'b0);
    run_cycle(1'b1, 3'b000, 1'b0);
    run_instr(3'b000, 1'b0, -1, 0);   // LDA
    run_instr(3'b001, 1'b0, -1, 0);   // STA
    run_instr(3'b101, 1'b1, -1, 0);   // JZ taken
    run_instr(3'b101, 1'b0, -1, 0);   // JZ not taken
    run_instr(3'b010, 1'b0, -1, 0);   // ADD
    run_instr(3'b011, 1'b1, -1, 0);   // SUB
    run_instr(3'b110, 1'b0, -1, 0);   // CLR
    run_instr(3'b100, 1'b0, -1, 0);   // JMP
    run_instr(3'b111, 1'b0, -1, 20);  // HLT (halt or NOP)
    run_instr(3'b000, 1'b0, 3, 0);    // LDA reset in EX0
    run_instr(3'b000, 1'b0, -1, 0);
    // Randomized instruction stream with occasional resets and halts.
    for (int i = 0; i < 300; i++) begin
      op  = $urandom_range(0, 7);
      rat = ($urandom_range(0, 15) == 0) ? $urandom_range(0, instr_len(3'(op)) - 1) : -1;
      run_instr(3'(op), 1'($urandom), rat, $urandom_range(1, 6));
    end
    // Drain the scoreboard with a bounded wait.
    for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      errors = errors + 1;
      $display("FAIL drain pending=%0d want 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
